// File: rtl/game_turn_fsm.sv
// rtl/game_turn_fsm.sv - turn-sequencing FSM for an N-player turn-based game
//
// Purpose: owns the game state register, current-player index, alive mask,
// inter-turn sleep timer and winner detection. Sits between the input and
// collision logic and the renderer/HUD; the state code drives sprite and
// text muxes.
//
// Optional feature macro: GAME_TURN_TIMEOUT_EN (forced turn end after
// TIMEOUT_TICKS frame ticks in TURN). Undefined: TURN waits indefinitely and
// timeout stays 0.
//
// Ports:
//   Clk          in   system clock
//   Reset        in   asynchronous, active-high reset
//   frame_tick   in   1-cycle pulse per video frame; all timers count on it
//   menu_req     in   pulse: IDLE/ENDGAME -> MENU
//   start        in   level: MENU -> TURN (new game)
//   move_done    in   pulse: current player finished its move
//   player_hit   in   bit i = player i knocked out this cycle
//   state        out  registered state code
//   cur_player   out  index of the player whose turn it is
//   alive        out  alive mask
//   winner       out  winning player index, valid when winner_valid
//   winner_valid out  1 in ENDGAME with exactly one survivor
//   timeout      out  1-cycle pulse on forced turn end
module game_turn_fsm #(
  parameter int NUM_PLAYERS   = 2,
  parameter int SLEEP_TICKS   = 30,
  parameter int TIMEOUT_TICKS = 600,
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic                   menu_req,
  input  logic                   start,
  input  logic                   move_done,
  input  logic [NUM_PLAYERS-1:0] player_hit,
  output logic [3:0]             state,
  output logic [PW-1:0]          cur_player,
  output logic [NUM_PLAYERS-1:0] alive,
  output logic [PW-1:0]          winner,
  output logic                   winner_valid,
  output logic                   timeout
);

  localparam int SCW = $clog2(SLEEP_TICKS + 1);

  typedef enum logic [3:0] {
    IDLE    = 4'h0,
    TURN    = 4'h1,
    SLEEP   = 4'h3,
    DOWN    = 4'h4,
    ENDGAME = 4'h6,
    MENU    = 4'hF
  } state_t;

  state_t                 state_q, state_n;
  logic [PW-1:0]          cur_n, winner_n, next_alive, sole_idx;
  logic [NUM_PLAYERS-1:0] alive_n, hit;
  logic                   wv_n, timeout_n;
  logic [SCW-1:0]         sleep_cnt, sleep_n;
  int                     alive_cnt;

`ifdef GAME_TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] turn_cnt, turn_n;
`endif

  assign hit   = player_hit & alive;
  assign state = state_q;

  // Nearest alive player strictly after cur_player in rotation order;
  // distance 0 (the current player itself) is never chosen.
  always_comb begin
    int best_d;
    int d;
    next_alive = cur_player;
    best_d     = NUM_PLAYERS;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      d = (j - int'(cur_player) + NUM_PLAYERS) % NUM_PLAYERS;
      if (alive[j] && d != 0 && d < best_d) begin
        best_d     = d;
        next_alive = PW'(j);
      end
    end
  end

  // Survivor count and the index of a survivor (meaningful when count is 1).
  always_comb begin
    alive_cnt = 0;
    sole_idx  = '0;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      if (alive[j]) begin
        alive_cnt = alive_cnt + 1;
        sole_idx  = PW'(j);
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    cur_n     = cur_player;
    alive_n   = alive;
    winner_n  = winner;
    wv_n      = winner_valid;
    sleep_n   = sleep_cnt;
    timeout_n = 1'b0;
`ifdef GAME_TURN_TIMEOUT_EN
    turn_n    = turn_cnt;
`endif
    case (state_q)
      IDLE: begin
        if (menu_req) state_n = MENU;
      end
      MENU: begin
        if (start) begin
          state_n  = TURN;
          alive_n  = '1;
          cur_n    = '0;
          winner_n = '0;
          wv_n     = 1'b0;
`ifdef GAME_TURN_TIMEOUT_EN
          turn_n   = '0;
`endif
        end
      end
      TURN: begin
        // A knock-out takes priority over a finished move in the same cycle.
        if (hit != '0) begin
          state_n = DOWN;
          alive_n = alive & ~player_hit;
        end else if (move_done) begin
          state_n = SLEEP;
          sleep_n = SCW'(SLEEP_TICKS);
        end
`ifdef GAME_TURN_TIMEOUT_EN
        else if (frame_tick) begin
          if (turn_cnt == TW'(TIMEOUT_TICKS - 1)) begin
            state_n   = SLEEP;
            sleep_n   = SCW'(SLEEP_TICKS);
            timeout_n = 1'b1;
          end else begin
            turn_n = turn_cnt + 1'b1;
          end
        end
`endif
      end
      SLEEP: begin
        if (hit != '0) begin
          state_n = DOWN;
          alive_n = alive & ~player_hit;
        end else if (frame_tick) begin
          if (sleep_cnt == SCW'(1)) begin
            state_n = TURN;
            cur_n   = next_alive;
`ifdef GAME_TURN_TIMEOUT_EN
            turn_n  = '0;
`endif
          end else begin
            sleep_n = sleep_cnt - 1'b1;
          end
        end
      end
      DOWN: begin
        if (alive_cnt <= 1) begin
          state_n = ENDGAME;
          if (alive_cnt == 1) begin
            winner_n = sole_idx;
            wv_n     = 1'b1;
          end else begin
            wv_n     = 1'b0;
          end
        end else begin
          state_n = SLEEP;
          sleep_n = SCW'(SLEEP_TICKS);
        end
      end
      ENDGAME: begin
        if (menu_req) state_n = MENU;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cur_player   <= '0;
      alive        <= '1;
      winner       <= '0;
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
      sleep_cnt    <= '0;
`ifdef GAME_TURN_TIMEOUT_EN
      turn_cnt     <= '0;
`endif
    end else begin
      state_q      <= state_n;
      cur_player   <= cur_n;
      alive        <= alive_n;
      winner       <= winner_n;
      winner_valid <= wv_n;
      timeout      <= timeout_n;
      sleep_cnt    <= sleep_n;
`ifdef GAME_TURN_TIMEOUT_EN
      turn_cnt     <= turn_n;
`endif
    end
  end

endmodule

// File: tb/tb_game_turn_fsm.sv
// tb/tb_game_turn_fsm.sv - directed self-checking bench for game_turn_fsm
module tb_game_turn_fsm;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick, menu_req, start, move_done;
  logic [3:0] player_hit;
  logic [3:0] state;
  logic [1:0] cur_player;
  logic [3:0] alive;
  logic [1:0] winner;
  logic       winner_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  game_turn_fsm #(
    .NUM_PLAYERS  (4),
    .SLEEP_TICKS  (2),
    .TIMEOUT_TICKS(5)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .menu_req    (menu_req),
    .start       (start),
    .move_done   (move_done),
    .player_hit  (player_hit),
    .state       (state),
    .cur_player  (cur_player),
    .alive       (alive),
    .winner      (winner),
    .winner_valid(winner_valid),
    .timeout     (timeout)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic pass_turn();
    move_done = 1'b1; cyc(); move_done = 1'b0;
    frame_tick = 1'b1; cyc(); cyc(); frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    total++; if (state !== 4'h0) begin bad++; $display("FAIL reset_state got=%h exp=0", state); end
    total++; if (cur_player !== 2'd0) begin bad++; $display("FAIL reset_cur got=%0d exp=0", cur_player); end
    total++; if (alive !== 4'b1111) begin bad++; $display("FAIL reset_alive got=%b exp=1111", alive); end
    total++; if (winner !== 2'd0) begin bad++; $display("FAIL reset_winner got=%0d exp=0", winner); end
    total++; if (winner_valid !== 1'b0) begin bad++; $display("FAIL reset_wv got=%b exp=0", winner_valid); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    Reset = 1'b0;
    start = 1'b1; move_done = 1'b1; player_hit = 4'b0001; cyc();
    start = 1'b0; move_done = 1'b0; player_hit = 4'b0000;
    total++; if (state !== 4'h0) begin bad++; $display("FAIL idle_ignore got=%h exp=0", state); end
    total++; if (alive !== 4'b1111) begin bad++; $display("FAIL idle_alive got=%b exp=1111", alive); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_cur [3];
    exp_cur = '{2'd2, 2'd3, 2'd0};
    menu_req = 1'b1; cyc(); menu_req = 1'b0;
    total++; if (state !== 4'hF) begin bad++; $display("FAIL menu_state got=%h exp=F", state); end
    start = 1'b1; cyc(); start = 1'b0;
    total++; if (state !== 4'h1) begin bad++; $display("FAIL start_state got=%h exp=1", state); end
    total++; if (cur_player !== 2'd0) begin bad++; $display("FAIL start_cur got=%0d exp=0", cur_player); end
    move_done = 1'b1; cyc(); move_done = 1'b0;
    total++; if (state !== 4'h3) begin bad++; $display("FAIL sleep_entry got=%h exp=3", state); end
    frame_tick = 1'b1; cyc();
    total++; if (state !== 4'h3) begin bad++; $display("FAIL sleep_hold got=%h exp=3", state); end
    cyc(); frame_tick = 1'b0;
    total++; if (state !== 4'h1) begin bad++; $display("FAIL sleep_exit got=%h exp=1", state); end
    total++; if (cur_player !== 2'd1) begin bad++; $display("FAIL rot_cur1 got=%0d exp=1", cur_player); end
    for (int i = 0; i < 3; i++) begin
      pass_turn();
      total++;
      if (cur_player !== exp_cur[i]) begin
        bad++; $display("FAIL rot_cur step=%0d got=%0d exp=%0d", i, cur_player, exp_cur[i]);
      end
    end
  endtask

  task automatic test_skip_dead();
    player_hit = 4'b0100; cyc(); player_hit = 4'b0000;
    total++; if (state !== 4'h4) begin bad++; $display("FAIL ko_down got=%h exp=4", state); end
    total++; if (alive !== 4'b1011) begin bad++; $display("FAIL ko_alive got=%b exp=1011", alive); end
    cyc();
    total++; if (state !== 4'h3) begin bad++; $display("FAIL ko_sleep got=%h exp=3", state); end
    frame_tick = 1'b1; cyc(); cyc(); frame_tick = 1'b0;
    total++; if (cur_player !== 2'd1) begin bad++; $display("FAIL skip_cur1 got=%0d exp=1", cur_player); end
    pass_turn();
    total++; if (cur_player !== 2'd3) begin bad++; $display("FAIL skip_dead got=%0d exp=3", cur_player); end
    pass_turn();
    total++; if (cur_player !== 2'd0) begin bad++; $display("FAIL skip_wrap got=%0d exp=0", cur_player); end
  endtask

  task automatic test_hit_beats_move();
    move_done = 1'b1; player_hit = 4'b0010; cyc();
    move_done = 1'b0; player_hit = 4'b0000;
    total++; if (state !== 4'h4) begin bad++; $display("FAIL hitmove_state got=%h exp=4", state); end
    total++; if (alive !== 4'b1001) begin bad++; $display("FAIL hitmove_alive got=%b exp=1001", alive); end
    cyc();
    total++; if (state !== 4'h3) begin bad++; $display("FAIL hitmove_sleep got=%h exp=3", state); end
    player_hit = 4'b0100; cyc(); player_hit = 4'b0000;
    total++; if (state !== 4'h3) begin bad++; $display("FAIL deadhit_state got=%h exp=3", state); end
    total++; if (alive !== 4'b1001) begin bad++; $display("FAIL deadhit_alive got=%b exp=1001", alive); end
  endtask

  task automatic test_winner();
    frame_tick = 1'b1; cyc();
    player_hit = 4'b0001; cyc();
    frame_tick = 1'b0; player_hit = 4'b0000;
    total++; if (state !== 4'h4) begin bad++; $display("FAIL hit_over_expiry got=%h exp=4", state); end
    total++; if (alive !== 4'b1000) begin bad++; $display("FAIL win_alive got=%b exp=1000", alive); end
    cyc();
    total++; if (state !== 4'h6) begin bad++; $display("FAIL win_endgame got=%h exp=6", state); end
    total++; if (winner !== 2'd3) begin bad++; $display("FAIL win_idx got=%0d exp=3", winner); end
    total++; if (winner_valid !== 1'b1) begin bad++; $display("FAIL win_valid got=%b exp=1", winner_valid); end
    move_done = 1'b1; frame_tick = 1'b1; player_hit = 4'b1000; cyc();
    move_done = 1'b0; frame_tick = 1'b0; player_hit = 4'b0000;
    total++; if (state !== 4'h6) begin bad++; $display("FAIL endgame_hold got=%h exp=6", state); end
    total++; if (alive !== 4'b1000) begin bad++; $display("FAIL endgame_alive got=%b exp=1000", alive); end
    menu_req = 1'b1; cyc(); menu_req = 1'b0;
    total++; if (state !== 4'hF) begin bad++; $display("FAIL end_menu got=%h exp=F", state); end
    total++; if (winner !== 2'd3) begin bad++; $display("FAIL menu_winner got=%0d exp=3", winner); end
    start = 1'b1; cyc(); start = 1'b0;
    total++; if (alive !== 4'b1111) begin bad++; $display("FAIL newgame_alive got=%b exp=1111", alive); end
    total++; if (winner_valid !== 1'b0) begin bad++; $display("FAIL newgame_wv got=%b exp=0", winner_valid); end
    total++; if (winner !== 2'd0) begin bad++; $display("FAIL newgame_winner got=%0d exp=0", winner); end
  endtask

  task automatic test_draw();
    player_hit = 4'b1111; cyc(); player_hit = 4'b0000;
    total++; if (alive !== 4'b0000) begin bad++; $display("FAIL draw_alive got=%b exp=0000", alive); end
    cyc();
    total++; if (state !== 4'h6) begin bad++; $display("FAIL draw_endgame got=%h exp=6", state); end
    total++; if (winner_valid !== 1'b0) begin bad++; $display("FAIL draw_wv got=%b exp=0", winner_valid); end
    menu_req = 1'b1; cyc(); menu_req = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    total++; if (state !== 4'h1) begin bad++; $display("FAIL draw_restart got=%h exp=1", state); end
  endtask

  task automatic test_timeout();
    frame_tick = 1'b1; repeat (4) cyc();
    total++; if (state !== 4'h1) begin bad++; $display("FAIL to_pre_state got=%h exp=1", state); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_pre_pulse got=%b exp=0", timeout); end
    cyc(); frame_tick = 1'b0;
`ifdef GAME_TURN_TIMEOUT_EN
    total++; if (state !== 4'h3) begin bad++; $display("FAIL to_state got=%h exp=3", state); end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b exp=1", timeout); end
    cyc();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_width got=%b exp=0", timeout); end
    frame_tick = 1'b1; cyc(); cyc();
    total++; if (state !== 4'h1) begin bad++; $display("FAIL to_next_turn got=%h exp=1", state); end
    total++; if (cur_player !== 2'd1) begin bad++; $display("FAIL to_next_cur got=%0d exp=1", cur_player); end
    repeat (4) cyc();
    move_done = 1'b1; cyc(); move_done = 1'b0; frame_tick = 1'b0;
    total++; if (state !== 4'h3) begin bad++; $display("FAIL to_move_state got=%h exp=3", state); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_move_nopulse got=%b exp=0", timeout); end
`else
    total++; if (state !== 4'h1) begin bad++; $display("FAIL noto_state got=%h exp=1", state); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL noto_pulse got=%b exp=0", timeout); end
`endif
  endtask

  task automatic test_reset_mid_sleep();
    player_hit = 4'b0010; cyc(); player_hit = 4'b0000;
    cyc();
    total++; if (state !== 4'h3) begin bad++; $display("FAIL rms_pre got=%h exp=3", state); end
    total++; if (alive !== 4'b1101) begin bad++; $display("FAIL rms_pre_alive got=%b exp=1101", alive); end
    Reset = 1'b1; #1;
    total++; if (state !== 4'h0) begin bad++; $display("FAIL rms_async got=%h exp=0", state); end
    cyc(); Reset = 1'b0;
    total++; if (state !== 4'h0) begin bad++; $display("FAIL rms_state got=%h exp=0", state); end
    total++; if (cur_player !== 2'd0) begin bad++; $display("FAIL rms_cur got=%0d exp=0", cur_player); end
    total++; if (alive !== 4'b1111) begin bad++; $display("FAIL rms_alive got=%b exp=1111", alive); end
    total++; if (winner_valid !== 1'b0) begin bad++; $display("FAIL rms_wv got=%b exp=0", winner_valid); end
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; menu_req = 1'b0; start = 1'b0;
    move_done = 1'b0; player_hit = 4'b0000;
    test_reset();
    test_rotation();
    test_skip_dead();
    test_hit_beats_move();
    test_winner();
    test_draw();
    test_timeout();
    test_reset_mid_sleep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
